// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a single-ported data memory.
// Supports round-robin or port-0 priority with a port-1 starvation guard.
module data_memory_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [15:0] addr0,
    input  logic [15:0] wdata0,
    output logic        gnt0,
    output logic        rvalid0,
    output logic [15:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata1,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [15:0] rdata1,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_write_data,
    output logic        mem_write_en,
    input  logic [15:0] mem_read_data
);

    localparam logic [3:0] WMAX = 4'(MAX_WAIT);

    // last_gnt_q: 1 means port 1 was granted last, so port 0 wins next contention
    logic        last_gnt_q, last_gnt_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;
    logic [15:0] rdata0_q, rdata0_d;
    logic [15:0] rdata1_q, rdata1_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
            wait_cnt_q <= 4'd0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= 16'd0;
            rdata1_q   <= 16'd0;
        end else begin
            last_gnt_q <= last_gnt_d;
            wait_cnt_q <= wait_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Grants are forced low while reset is asserted so no write can slip through
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            unique case ({req1, req0})
                2'b01: gnt0 = 1'b1;
                2'b10: gnt1 = 1'b1;
                2'b11: begin
                    if (PRIO_MODE == 0) begin
                        gnt0 = last_gnt_q;
                        gnt1 = ~last_gnt_q;
                    end else begin
                        gnt1 = (wait_cnt_q == WMAX);
                        gnt0 = ~gnt1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt0) last_gnt_d = 1'b0;
        if (gnt1) last_gnt_d = 1'b1;

        wait_cnt_d = 4'd0;
        if (req1 && !gnt1) begin
            wait_cnt_d = (wait_cnt_q >= WMAX) ? WMAX : wait_cnt_q + 4'd1;
        end

        rvalid0_d = gnt0 & ~we0;
        rvalid1_d = gnt1 & ~we1;
        rdata0_d  = rvalid0_d ? mem_read_data : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_read_data : rdata1_q;
    end

    always_comb begin
        mem_addr       = gnt1 ? addr1 : addr0;
        mem_write_data = gnt1 ? wdata1 : wdata0;
        mem_write_en   = (gnt0 & we0) | (gnt1 & we1);
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench: round-robin and priority instances, each with a
// transaction-level arbitration model and its own data memory.
module tb_data_memory_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit done [2];

    typedef struct packed {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    localparam int MW = 4;

    task automatic chk(input string nm, input logic [47:0] act,
                       input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic r, input logic w,
                                input logic [15:0] a, input logic [15:0] d);
        txn_t t;
        t.req   = r;
        t.we    = w;
        t.addr  = a;
        t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rnd();
        txn_t t;
        t.req   = ($urandom_range(0, 9) < 7);
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                              : 16'($urandom_range(0, 15));
        t.wdata = 16'($urandom);
        return t;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        logic        rst_n, req0, req1, we0, we1, gnt0, gnt1;
        logic        rvalid0, rvalid1, mem_write_en;
        logic [15:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;
        logic [15:0] mem_addr, mem_write_data, mem_read_data;
        logic [15:0] mem  [256];
        logic [15:0] mram [256];
        logic [15:0] exp0 [$];
        logic [15:0] exp1 [$];
        logic [15:0] h0, h1;
        txn_t        dq0 [$];
        txn_t        dq1 [$];
        txn_t        p0, p1;
        int          gtrace [$];
        bit          rand_on;
        int          last, denied;
        int          rr_pat [6] = '{0, 1, 0, 1, 0, 1};
        int          pr_pat [6] = '{0, 0, 0, 0, 1, 0};

        data_memory_arbiter #(.PRIO_MODE(g), .MAX_WAIT(MW)) dut (
            .clk(clk), .rst_n(rst_n),
            .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
            .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
            .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
            .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
            .mem_addr(mem_addr), .mem_write_data(mem_write_data),
            .mem_write_en(mem_write_en), .mem_read_data(mem_read_data)
        );

        assign mem_read_data = mem[mem_addr[7:0]];
        always @(posedge clk)
            if (mem_write_en) mem[mem_addr[7:0]] <= mem_write_data;

        always @(negedge clk) begin
            if (rvalid0) begin
                if (exp0.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL u%0d_rvalid0: pulse with no read pending", g);
                end else begin
                    h0 = exp0.pop_front();
                    chk($sformatf("u%0d_rdata0", g), 48'(rdata0), 48'(h0));
                end
            end else begin
                chk($sformatf("u%0d_rdata0_hold", g), 48'(rdata0), 48'(h0));
            end
            if (rvalid1) begin
                if (exp1.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL u%0d_rvalid1: pulse with no read pending", g);
                end else begin
                    h1 = exp1.pop_front();
                    chk($sformatf("u%0d_rdata1", g), 48'(rdata1), 48'(h1));
                end
            end else begin
                chk($sformatf("u%0d_rdata1_hold", g), 48'(rdata1), 48'(h1));
            end
        end

        task automatic chk_rst(input string nm);
            chk($sformatf("u%0d_%s", g, nm),
                48'({gnt0, gnt1, mem_write_en, rvalid0, rvalid1, rdata0, rdata1}),
                48'd0);
        endtask

        // Called at a falling edge: present inputs, check grant and bus, advance model
        task automatic step();
            int          ge;
            logic        r1;
            txn_t        t;
            logic [32:0] bus;
            if (!p0.req) p0 = dq0.size() ? dq0.pop_front()
                                          : (rand_on ? rnd() : mk(0, 0, 0, 0));
            if (!p1.req) p1 = dq1.size() ? dq1.pop_front()
                                          : (rand_on ? rnd() : mk(0, 0, 0, 0));
            req0 = p0.req; we0 = p0.we; addr0 = p0.addr; wdata0 = p0.wdata;
            req1 = p1.req; we1 = p1.we; addr1 = p1.addr; wdata1 = p1.wdata;
            #1;
            if (p0.req && p1.req) begin
                if (g == 0) ge = (last == 1) ? 0 : 1;
                else        ge = (denied == MW) ? 1 : 0;
            end else if (p0.req) ge = 0;
            else if (p1.req)     ge = 1;
            else                 ge = -1;
            gtrace.push_back(gnt1 ? 1 : (gnt0 ? 0 : -1));
            chk($sformatf("u%0d_gnt", g), 48'({gnt1, gnt0}),
                48'((ge == 1) ? 2'b10 : (ge == 0) ? 2'b01 : 2'b00));
            if (ge == 1)      bus = {p1.we, p1.addr, p1.wdata};
            else if (ge == 0) bus = {p0.we, p0.addr, p0.wdata};
            else              bus = {1'b0, p0.addr, p0.wdata};
            chk($sformatf("u%0d_mem_bus", g),
                48'({mem_write_en, mem_addr, mem_write_data}), 48'(bus));
            r1 = p1.req;
            if (ge >= 0) begin
                t = (ge == 0) ? p0 : p1;
                if (t.we)         mram[t.addr[7:0]] = t.wdata;
                else if (ge == 0) exp0.push_back(mram[t.addr[7:0]]);
                else              exp1.push_back(mram[t.addr[7:0]]);
                if (ge == 0) p0.req = 1'b0;
                else         p1.req = 1'b0;
                last = ge;
            end
            if (r1 && ge != 1) denied = (denied < MW) ? denied + 1 : MW;
            else               denied = 0;
        endtask

        task automatic run_idle(input int budget);
            int n = 0;
            while ((dq0.size() != 0 || dq1.size() != 0 || p0.req || p1.req ||
                    exp0.size() != 0 || exp1.size() != 0) && n < budget) begin
                @(negedge clk);
                step();
                n++;
            end
            chk($sformatf("u%0d_drain", g), 48'(n < budget), 48'd1);
        endtask

        // Reset lands in the same cycle as a port-1 write grant
        task automatic reset_mid();
            @(negedge clk);
            req0 = 1'b0; req1 = 1'b1; we1 = 1'b1;
            addr1 = 16'h0020; wdata1 = 16'h1234;
            #1;
            chk($sformatf("u%0d_pre_rst_gnt1", g),
                48'({gnt1, mem_write_en}), 48'b11);
            rst_n = 1'b0;
            h0 = 16'd0;
            h1 = 16'd0;
            #1;
            chk_rst("mid_rst_out");
            @(negedge clk);
            #1;
            chk_rst("mid_rst_hold");
            chk($sformatf("u%0d_ram20", g), 48'(mem[8'h20]), 48'h0020);
            last = 1;
            denied = 0;
            p0 = mk(0, 0, 0, 0);
            p1 = mk(0, 0, 0, 0);
            gtrace.delete();
            @(negedge clk);
            rst_n = 1'b1;
            step();
        endtask

        initial begin
            rst_n = 1'b0;
            req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
            addr0 = 16'h0003; addr1 = 16'h0004;
            wdata0 = 16'hAAAA; wdata1 = 16'h5555;
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 16'(i);
                mram[i] = 16'(i);
            end
            last = 1;
            denied = 0;
            h0 = 16'd0;
            h1 = 16'd0;
            rand_on = 1'b0;
            p0 = mk(0, 0, 0, 0);
            p1 = mk(0, 0, 0, 0);
            #3;
            chk_rst("rst_out");
            @(negedge clk);
            #1;
            chk_rst("rst_out_hold");

            dq0.push_back(mk(1, 0, 16'h0005, 16'h0));
            @(negedge clk);
            rst_n = 1'b1;
            step();
            run_idle(20);
            chk($sformatf("u%0d_read5", g), 48'(rdata0), 48'h0005);

            dq1.push_back(mk(1, 1, 16'h0010, 16'hBEEF));
            dq0.push_back(mk(0, 0, 16'h0000, 16'h0));
            dq0.push_back(mk(1, 0, 16'h0010, 16'h0));
            run_idle(20);
            chk($sformatf("u%0d_beef", g), 48'(rdata0), 48'hBEEF);

            for (int i = 0; i < 8; i++) begin
                dq0.push_back(mk(1, 0, 16'h0001, 16'h0));
                dq1.push_back(mk(1, 0, 16'h0002, 16'h0));
            end
            reset_mid();
            run_idle(40);
            for (int i = 0; i < 6; i++)
                chk($sformatf("u%0d_pattern%0d", g, i), 48'(gtrace[i]),
                    48'((g == 0) ? rr_pat[i] : pr_pat[i]));
            chk($sformatf("u%0d_rd1", g), 48'({rdata0, rdata1}),
                48'({16'h0001, 16'h0002}));

            rand_on = 1'b1;
            repeat (500) begin
                @(negedge clk);
                step();
            end
            rand_on = 1'b0;
            run_idle(60);
            done[g] = 1'b1;
        end
    end

    initial begin
        int k = 0;
        while (!(done[0] && done[1]) && k < 5000) begin
            @(posedge clk);
            k++;
        end
        if (!(done[0] && done[1])) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: done=%0b%0b required 11", done[1], done[0]);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter PRIO_MODE, default 0: 0 = round-robin, 1 = port 0 priority with starvation guard.
REQ-002 Parameter MAX_WAIT, default 4, legal range 1..15: maximum consecutive denied cycles for port 1 in PRIO_MODE=1.
REQ-003 The design SHALL use one clock; reset is asynchronous and active-low. Ports: clk, rst_n.
REQ-004 clk  input  1  rising-edge clock for all state and memory writes.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req0/req1  input  1  access request; held with its address, data and direction until granted.
REQ-007 we0/we1  input  1  1 = write, 0 = read.
REQ-008 addr0/addr1  input  16  word address.
REQ-009 wdata0/wdata1  input  16  write data.
REQ-010 gnt0/gnt1  output  1  combinational grant; the access completes at the rising edge where it is high.
REQ-011 rvalid0/rvalid1  output  1  one-cycle pulse, read data valid.
REQ-012 rdata0/rdata1  output  16  registered read data.
REQ-013 mem_addr  output  16  data memory address.
REQ-014 mem_write_data  output  16  data memory write data.
REQ-015 mem_write_en  output  1  data memory write enable.
REQ-016 mem_read_data  input  16  asynchronous read data from data memory; only addr[7:0] is decoded by the memory.

Function
REQ-017 At most one of gnt0 and gnt1 SHALL be high in any cycle; a lone requester is granted in the same cycle.
REQ-018 With no requests: gnt0=gnt1=0, mem_write_en=0, mem_addr=addr0, mem_write_data=wdata0.
REQ-019 When gntK is high: mem_addr=addrK, mem_write_data=wdataK, mem_write_en=weK.
REQ-020 Round-robin (PRIO_MODE=0) SHALL use register last_gnt: on contention, grant the port not equal to last_gnt; last_gnt updates to the granted port at every edge with a grant.
REQ-021 Priority mode (PRIO_MODE=1): on contention, grant port 0 unless wait_cnt==MAX_WAIT, in which case grant port 1.
REQ-022 wait_cnt (4 bits) SHALL increment at each edge where req1=1 and gnt1=0, saturate at MAX_WAIT, and clear at each edge where gnt1=1 or req1=0.
REQ-023 Read: at the edge where gntK=1 and weK=0, rdataK SHALL load mem_read_data and rvalidK SHALL be 1 for the following cycle only; latency is 1 cycle from grant.
REQ-024 rdataK SHALL hold its value until the next read on port K; writes SHALL NOT pulse rvalidK.
REQ-025 Back-to-back grants to the same port SHALL produce back-to-back rvalid pulses.
REQ-026 Addresses SHALL pass through unmodified at 16 bits; aliasing above 0xFF is the memory's behaviour and is not checked.
REQ-027 Port 1 read in the same cycle as a port 0 write to the same address SHALL be serialized by grant order: the later-granted access observes the earlier write.

Reset
REQ-028 While rst_n=0: gnt0=gnt1=0, mem_write_en=0, rvalid0=rvalid1=0, rdata0=rdata1=0, last_gnt=1 (port 0 wins the first contention), wait_cnt=0.
REQ-029 Assertion of rst_n mid-access SHALL suppress the pending write; no grant is counted as complete, and requesters re-present after release.
REQ-030 Grants SHALL resume in the first cycle with rst_n=1.

Verification
REQ-031 Port 0 reads 0x0005 from a memory initialised with ram[i]=i -> gnt0 the same cycle, rvalid0 pulse next cycle, rdata0=0x0005.
REQ-032 Port 1 writes 0xBEEF to 0x0010, then port 0 reads 0x0010 -> rdata0=0xBEEF; rvalid1 stays 0.
REQ-033 PRIO_MODE=0, both ports request reads continuously from 0x0001/0x0002 -> grants alternate 0,1,0,1; rdata values are 0x0001/0x0002 respectively.
REQ-034 PRIO_MODE=1, MAX_WAIT=4, both ports request continuously -> port 1 is granted on the 5th cycle, then port 0 four times, repeating.
REQ-035 rst_n pulled low in the same cycle as gnt1 with we1=1, 0x1234 to 0x0020 -> ram[0x20] keeps 0x0020; all outputs are 0 during reset.
